uart_word_tx: RTL and testbench

//  Client of the UART transmit handshake (tx_start / data_in / tx_done_tick) in the debug unit.

---
 rtl/uart_word_tx.sv | 169 ++++++++++++++++
 tb/tb_uart_word_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// Buffers 32-bit debug words and sends each one to the UART as NBYTES bytes, least significant byte first.
// Latency: a word accepted into an empty FIFO while idle is popped on the next edge, and tx_start is high the cycle after that.
// Backpressure: word_ready drops when the FIFO is full, words offered then are dropped and set the sticky overflow flag.
// Define UART_WORD_CHECKSUM_EN to send an extra XOR checksum byte after each word.
module uart_word_tx #(
   parameter int NBITS      = 8,
   parameter int WORD_BITS  = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          CLK_100MHZ,
   input  logic                          reset,
   input  logic                          word_valid,
   input  logic [WORD_BITS-1:0]          word_in,
   output logic                          word_ready,
   output logic                          tx_start,
   output logic [NBITS-1:0]              tx_data,
   input  logic                          tx_done_tick,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int NBYTES = WORD_BITS / NBITS;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [BW-1:0] LAST_IDX = BW'(NBYTES - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_WORD_CHECKSUM_EN
   // CHK issues the checksum tx_start pulse; CHK_WAIT waits for that byte to leave the UART.
   typedef enum logic [2:0] {IDLE, SEND, WAIT, CHK, CHK_WAIT} state_t;
`else
   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
`endif

   state_t                 state_q, state_d;
   logic [WORD_BITS-1:0]   sh_q, sh_d;
   logic [BW-1:0]          idx_q, idx_d;
   logic [WORD_BITS-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [AW:0]            cnt_q;
   logic                   ovf_q;
   logic                   full, empty, push, pop;

`ifdef UART_WORD_CHECKSUM_EN
   logic [NBITS-1:0]       csum_q, csum_d;

   function automatic logic [NBITS-1:0] xor_bytes(input logic [WORD_BITS-1:0] w);
      logic [NBITS-1:0] r;
      r = '0;
      for (int i = 0; i < NBYTES; i++) begin
         r = r ^ w[i*NBITS +: NBITS];
      end
      return r;
   endfunction
`endif

   assign full       = (cnt_q == FULL_CNT);
   assign empty      = (cnt_q == '0);
   // Acceptance looks only at the registered count, so a same-cycle pop never frees room for a push.
   assign push       = word_valid && !full;
   assign word_ready = !full;
   assign tx_data    = sh_q[NBITS-1:0];
   assign busy       = (state_q != IDLE) || !empty;
   assign fifo_count = cnt_q;
   assign overflow   = ovf_q;

   // FIFO storage write (no reset needed: occupancy is tracked by the pointers)
   always_ff @(posedge CLK_100MHZ) begin
      if (push) begin
         mem_q[wr_ptr_q] <= word_in;
      end
   end

   // FIFO pointers, occupancy count and sticky overflow flag
   always_ff @(posedge CLK_100MHZ) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
            default: cnt_q <= cnt_q;
         endcase
         if (word_valid && full) ovf_q <= 1'b1;
      end
   end

   // Serialiser state register
   always_ff @(posedge CLK_100MHZ) begin
      if (reset) begin
         state_q <= IDLE;
         sh_q    <= '0;
         idx_q   <= '0;
`ifdef UART_WORD_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         idx_q   <= idx_d;
`ifdef UART_WORD_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   // Serialiser next state: pop a word, pulse tx_start per byte, advance on each done tick
   always_comb begin
      state_d  = state_q;
      sh_d     = sh_q;
      idx_d    = idx_q;
      pop      = 1'b0;
      tx_start = 1'b0;
`ifdef UART_WORD_CHECKSUM_EN
      csum_d   = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               sh_d    = mem_q[rd_ptr_q];
               idx_d   = '0;
`ifdef UART_WORD_CHECKSUM_EN
               csum_d  = xor_bytes(mem_q[rd_ptr_q]);
`endif
               state_d = SEND;
            end
         end
         SEND: begin
            tx_start = 1'b1;
            state_d  = WAIT;
         end
         WAIT: begin
            if (tx_done_tick) begin
               if (idx_q != LAST_IDX) begin
                  sh_d    = sh_q >> NBITS;
                  idx_d   = idx_q + BW'(1);
                  state_d = SEND;
               end else begin
`ifdef UART_WORD_CHECKSUM_EN
                  // Checksum goes out through the same shift register so tx_data needs no extra mux.
                  sh_d    = WORD_BITS'(csum_q);
                  state_d = CHK;
`else
                  state_d = IDLE;
`endif
               end
            end
         end
`ifdef UART_WORD_CHECKSUM_EN
         CHK: begin
            tx_start = 1'b1;
            state_d  = CHK_WAIT;
         end
         CHK_WAIT: begin
            if (tx_done_tick) state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: scoreboard of expected UART bytes plus a UART model.
// The model answers every tx_start with a one-cycle tx_done_tick 20 cycles later; it can be held.
// Build with UART_WORD_CHECKSUM_EN defined to expect the trailing checksum byte.
module tb_uart_word_tx;

`ifdef UART_WORD_CHECKSUM_EN
   localparam int NFR = 5;
`else
   localparam int NFR = 4;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        word_valid;
   logic [31:0] word_in;
   logic        word_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_done_tick;
   logic        busy;
   logic [2:0]  fifo_count;
   logic        overflow;

   logic        done_model = 1'b0;
   logic        done_man   = 1'b0;
   bit          uart_hold  = 1'b0;
   logic        prev_start = 1'b0;

   int          n_chk = 0;
   int          n_pass = 0;
   int          start_cnt = 0;
   int          done_cnt = 0;
   int          s0, d0;
   logic [7:0]  exp_q [$];

   assign tx_done_tick = done_model | done_man;

   always #5 clk = ~clk;

   uart_word_tx dut (
      .CLK_100MHZ   (clk),
      .reset        (reset),
      .word_valid   (word_valid),
      .word_in      (word_in),
      .word_ready   (word_ready),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .tx_done_tick (tx_done_tick),
      .busy         (busy),
      .fifo_count   (fifo_count),
      .overflow     (overflow)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic expect_word(input logic [31:0] w);
      logic [7:0] x;
      x = 8'h00;
      for (int b = 0; b < 4; b++) begin
         exp_q.push_back(w[b*8 +: 8]);
         x = x ^ w[b*8 +: 8];
      end
`ifdef UART_WORD_CHECKSUM_EN
      exp_q.push_back(x);
`endif
   endtask

   // Called #1 after a rising edge; offers one word for one cycle.
   task automatic drive_word(input logic [31:0] w, input bit exp_acc, input string tag);
      word_valid = 1'b1;
      word_in    = w;
      @(negedge clk);
      check_eq(tag, word_ready, exp_acc);
      if (exp_acc) expect_word(w);
      @(posedge clk);
      #1 word_valid = 1'b0;
   endtask

   task automatic wait_start(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (tx_start !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, tx_start, 1);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (tx_done_tick !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, tx_done_tick, 1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, busy, 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // UART model: answer each tx_start with a done tick 20 cycles later, unless held.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            repeat (20) @(posedge clk);
            while (uart_hold) @(posedge clk);
            #1 done_model = 1'b1;
            @(posedge clk);
            #1 done_model = 1'b0;
         end
      end
   end

   // Scoreboard monitor: every tx_start must carry the next expected byte and last one cycle.
   always @(negedge clk) begin
      if (tx_done_tick === 1'b1) done_cnt++;
      if (tx_start === 1'b1) begin
         start_cnt++;
         check_eq("start_pulse_width", prev_start, 0);
         if (exp_q.size() == 0) check_eq("unexpected_start", tx_start, 0);
         else check_eq("byte", tx_data, exp_q.pop_front());
      end
      prev_start <= (tx_start === 1'b1);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      word_valid = 1'b0;
      word_in    = 32'h0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset values
      @(negedge clk);
      check_eq("rst_tx_start", tx_start, 0);
      check_eq("rst_tx_data", tx_data, 0);
      check_eq("rst_word_ready", word_ready, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_fifo_count", fifo_count, 0);
      check_eq("rst_overflow", overflow, 0);

      // 1: single word, byte order and busy falling after the last done tick
      @(posedge clk); #1;
      s0 = start_cnt;
      drive_word(32'hDEADBEEF, 1'b1, "t1_acc");
      for (int i = 0; i < NFR; i++) begin
         wait_done("t1_done");
         @(negedge clk);
         check_eq($sformatf("t1_busy_after_done%0d", i), busy, (i < NFR - 1));
      end
      check_eq("t1_start_count", start_cnt - s0, NFR);

      // 2: first-byte latency and one-cycle inter-byte gap
      @(posedge clk); #1;
      drive_word(32'h00000001, 1'b1, "t2_acc");
      @(negedge clk);
      check_eq("t2_no_start_at_pop_cycle", tx_start, 0);
      @(negedge clk);
      check_eq("t2_start_latency", tx_start, 1);
      check_eq("t2_first_byte", tx_data, 8'h01);
      wait_done("t2_done");
      @(negedge clk);
      check_eq("t2_gap_start", tx_start, 1);
      check_eq("t2_second_byte", tx_data, 8'h00);
      wait_idle("t2_idle", 400);

      // 3: six back-to-back words with the UART stalled
      uart_hold = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) begin
         drive_word(32'hA0B0C0D0 + 32'h01010101 * i, (i < 5), $sformatf("t3_ready%0d", i));
      end
      @(negedge clk);
      check_eq("t3_fifo_count", fifo_count, 4);
      check_eq("t3_word_ready", word_ready, 0);
      check_eq("t3_overflow", overflow, 1);
      check_eq("t3_busy", busy, 1);
      uart_hold = 1'b0;
      wait_idle("t3_idle", 3000);
      check_eq("t3_all_sent", exp_q.size(), 0);

      // 4: full FIFO, push offered in the same cycle as a pop
      do_reset();
      @(negedge clk);
      check_eq("t4_overflow_cleared", overflow, 0);
      uart_hold = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         drive_word(32'h10203040 + 32'h11111111 * i, 1'b1, "t4_acc");
      end
      @(negedge clk);
      check_eq("t4_full_count", fifo_count, 4);
      uart_hold = 1'b0;
      for (int i = 0; i < NFR; i++) wait_done("t4_done");
      @(posedge clk);
      #1 word_valid = 1'b1;
      word_in = 32'h0BADF00D;
      @(negedge clk);
      check_eq("t4_ready_low_at_pop", word_ready, 0);
      check_eq("t4_count_before_pop", fifo_count, 4);
      @(posedge clk);
      #1 word_valid = 1'b0;
      @(negedge clk);
      check_eq("t4_count_after_pop", fifo_count, 3);
      check_eq("t4_overflow", overflow, 1);
      check_eq("t4_ready_after_pop", word_ready, 1);
      wait_idle("t4_idle", 3000);
      check_eq("t4_all_sent", exp_q.size(), 0);

      // 5: reset while waiting on the second byte
      @(posedge clk); #1;
      drive_word(32'hDEADBEEF, 1'b1, "t5_acc0");
      drive_word(32'h12345678, 1'b1, "t5_acc1");
      wait_start("t5_start0");
      wait_start("t5_start1");
      repeat (3) @(negedge clk);
      check_eq("t5_count_before_reset", fifo_count, 1);
      check_eq("t5_busy_before_reset", busy, 1);
      d0 = done_cnt;
      do_reset();
      @(negedge clk);
      check_eq("t5_busy", busy, 0);
      check_eq("t5_fifo_count", fifo_count, 0);
      check_eq("t5_tx_start", tx_start, 0);
      s0 = start_cnt;
      repeat (40) @(negedge clk);
      check_eq("t5_stray_done_seen", done_cnt - d0, 1);
      check_eq("t5_no_start_after_stray", start_cnt - s0, 0);

      // 6: done ticks while idle and empty
      s0 = start_cnt;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 done_man = 1'b1;
         @(posedge clk);
         #1 done_man = 1'b0;
         @(negedge clk);
         check_eq("t6_tx_start", tx_start, 0);
         check_eq("t6_busy", busy, 0);
      end
      check_eq("t6_no_starts", start_cnt - s0, 0);
      check_eq("t6_fifo_count", fifo_count, 0);

      // Still operational afterwards
      @(posedge clk); #1;
      drive_word(32'hCAFEF00D, 1'b1, "t7_acc");
      wait_idle("t7_idle", 400);
      check_eq("t7_all_sent", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
